// File: rtl/muldiv_e.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply, 32-cycle
// restoring divide, optional single-cycle completion of divide-by-zero and overflow.
module muldiv_e #(
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3E,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_main;
  logic        neg_rem;
  logic        div_zero;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        in_div0, in_ovf, special;
  logic [31:0] special_res;

  // Operand decode works on the raw inputs; only meaningful in IDLE when start is seen.
  always_comb begin
    a_signed    = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
    b_signed    = funct3E[2] ? ~funct3E[0] : ~funct3E[1];
    a_neg       = a_signed & RD1E[31];
    b_neg       = b_signed & RD2E[31];
    a_mag       = a_neg ? (32'd0 - RD1E) : RD1E;
    b_mag       = b_neg ? (32'd0 - RD2E) : RD2E;
    in_div0     = (RD2E == 32'd0);
    in_ovf      = ~funct3E[0] & (RD1E == 32'h8000_0000) & (RD2E == 32'hFFFF_FFFF);
    special     = EARLY_SPECIAL & funct3E[2] & (in_div0 | in_ovf);
    special_res = funct3E[1] ? (in_div0 ? RD1E : 32'd0)
                             : (in_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
  end

  logic [63:0] acc_next, prod;
  logic [32:0] rem_sh, trial;
  logic [31:0] rem_next, quo_next, q_fin, r_fin;

  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    prod     = neg_main ? (64'd0 - acc_next) : acc_next;
    rem_sh   = {rem, quo[31]};
    trial    = rem_sh - {1'b0, dvsr};
    rem_next = trial[32] ? rem_sh[31:0] : trial[31:0];
    quo_next = {quo[30:0], ~trial[32]};
    // A zero divisor already leaves remainder = |A|; only the quotient needs forcing.
    q_fin    = div_zero ? 32'hFFFF_FFFF : (neg_main ? (32'd0 - quo_next) : quo_next);
    r_fin    = neg_rem ? (32'd0 - rem_next) : rem_next;
  end

  assign busy  = (state == S_MUL) || (state == S_DIV);
  assign stall = ((state == S_IDLE) && start) || busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      op       <= 2'd0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      mplier   <= 32'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvsr     <= 32'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      result   <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op       <= funct3E[1:0];
              cnt      <= 5'd0;
              neg_main <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= in_div0;
              acc      <= 64'd0;
              mcand    <= {32'd0, a_mag};
              mplier   <= b_mag;
              rem      <= 32'd0;
              quo      <= a_mag;
              dvsr     <= b_mag;
              if (special) begin
                result <= special_res;
                done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                state <= funct3E[2] ? S_DIV : S_MUL;
              end
            end
          end
          S_MUL: begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= (op == 2'b00) ? prod[31:0] : prod[63:32];
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DIV: begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= op[1] ? r_fin : q_fin;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
